ultrasonic_distance_filter: RTL
===============================

// Module: ultrasonic_distance_filter
// PURPOSE
//  Cleans the raw 8-bit range stream from the ultrasonic sensor driver before drive
//  logic and the softcore PIO use it. Drops no-echo/timeout codes, rejects single-shot
//  outliers, and keeps a DEPTH-sample moving average. Flags loss of target after
//  repeated no-echo reads. Sits between sensor_driver (raw_distance) and the drive/LCD
//  consumers (avg_distance).
// PARAMETERS
//  W             8   sample/average width (bits)
//  DEPTH         8   moving-average window; power of 2, >=2
//  MAX_JUMP      20  max |sample - avg_distance| accepted once seeded
//  REJECT_LIMIT  3   consecutive outliers that force a reseed (>=1)
//  NO_ECHO_LIMIT 4   consecutive invalid codes that assert no_target (>=1)
// PORTS
//  clk           in   1  system clock, 50 MHz
//  reset_n       in   1  synchronous reset, active low
//  raw_distance  in   W  distance sample from sensor_driver
//  dist_valid    in   1  1-cycle strobe: raw_distance is a new sample
//  avg_distance  out  W  rounded moving average
//  avg_valid     out  1  1-cycle pulse: avg_distance just updated
//  seeded        out  1  window holds valid data
//  no_target     out  1  NO_ECHO_LIMIT consecutive invalid samples seen
// BEHAVIOUR
//  - Synchronous reset, active low; one clock domain. On reset: avg_distance=0,
//    avg_valid=0, seeded=0, no_target=0, sum=0, write pointer=0, both counters=0.
//    Window contents are don't-care. Any sample in flight is dropped.
//  - Pipeline: S1 registers the sample and its class. S2 updates the window, sum and
//    outputs. dist_valid at cycle t -> avg_distance/avg_valid at cycle t+2.
//  - dist_valid may be high every cycle; no backpressure; no sample is lost.
//  - Classification at S1 uses avg_distance as registered at cycle t. The result may be
//    up to 2 updates stale when samples arrive back-to-back; this is intended.
//  - INVALID: sample==0 or sample=={W{1}}. Window and reject counter unchanged.
//    no_echo_cnt++ (saturating at NO_ECHO_LIMIT); no_target=1 when it reaches the limit.
//  - Any non-INVALID sample clears no_echo_cnt and no_target (both at S2).
//  - SEED: (!seeded) OR (outlier AND reject_cnt==REJECT_LIMIT-1).
//    All DEPTH entries <= sample; sum <= sample<<log2(DEPTH); ptr <= 0;
//    reject_cnt <= 0; seeded <= 1; avg_distance <= sample; avg_valid=1.
//  - OUTLIER (seeded, |sample-avg_distance|>MAX_JUMP, not a seed): reject_cnt++.
//    No window update; avg_valid=0. Use W+1-bit signed difference for |x|.
//  - ACCEPT (seeded, diff<=MAX_JUMP): sum <= sum + sample - win[ptr]; win[ptr] <= sample;
//    ptr <= ptr+1, wrapping DEPTH-1->0; reject_cnt <= 0; avg_valid=1.
//  - sum is W+log2(DEPTH) bits and never overflows.
//    avg_distance = (sum_new + DEPTH/2) >> log2(DEPTH), round half up.
//  - avg_valid is high for exactly the one S2 cycle of a SEED or ACCEPT, else 0.
//  - seeded only returns to 0 through reset.
// TESTING (W=8, DEPTH=8, MAX_JUMP=20, REJECT_LIMIT=3, NO_ECHO_LIMIT=4)
//  1. Reset, single strobe raw=100 -> 2 cycles later: avg_distance=100, avg_valid
//     1 cycle, seeded=1.
//  2. Seeded at 100, strobe raw=108 -> sum=808, avg_distance=101; then seven more
//     strobes of 108 -> avg_distance=108, ptr wrapped to 0.
//  3. Seeded at 100, raw=150 x3 -> strobes 1-2 give no avg_valid and avg stays 100;
//     strobe 3 reseeds: avg_distance=150. Repeat with 150,150,110: the 110 resets the
//     outlier count and no reseed occurs.
//  4. Seeded at 100, raw=0 x4 -> no_target=1 at t+2 of the 4th; avg stays 100 and
//     avg_valid stays 0. Then raw=255 keeps no_target=1; then raw=95 clears no_target
//     and avg becomes 99.
//  5. Back-to-back strobes every cycle 100,100,125,125,125 after seed 100
//     -> 125s rejected, 3rd 125 reseeds to 125; no strobe dropped.
//  6. reset_n=0 one cycle after a dist_valid strobe -> that sample never updates the
//     outputs, all outputs 0. The next strobe of 60 seeds to 60.

Source files
------------

// File: rtl/ultrasonic_distance_filter.sv
// Range-stream cleaner: drops no-echo codes, rejects single-shot outliers and keeps a
// DEPTH-sample rounded moving average. Two stages: S1 classifies, S2 updates the window.
module ultrasonic_distance_filter #(
  parameter int W             = 8,
  parameter int DEPTH         = 8,
  parameter int MAX_JUMP      = 20,
  parameter int REJECT_LIMIT  = 3,
  parameter int NO_ECHO_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] raw_distance,
  input  logic         dist_valid,
  output logic [W-1:0] avg_distance,
  output logic         avg_valid,
  output logic         seeded,
  output logic         no_target
);

  localparam int LG = $clog2(DEPTH);
  localparam int SW = W + LG;
  localparam int RW = $clog2(REJECT_LIMIT + 1);
  localparam int NW = $clog2(NO_ECHO_LIMIT + 1);

  logic [W-1:0]  r_win [DEPTH];
  logic [SW-1:0] r_sum;
  logic [LG-1:0] r_ptr;
  logic [RW-1:0] r_rej;
  logic [NW-1:0] r_ne;
  logic [W-1:0]  r_avg;
  logic          r_avg_valid;
  logic          r_seeded;
  logic          r_no_target;

  logic          r_s1_valid;
  logic [W-1:0]  r_s1_sample;
  logic          r_s1_invalid;
  logic          r_s1_far;

  logic [W:0]    w_diff;
  logic [W:0]    w_absdiff;
  logic          w_invalid;
  logic          w_far;
  logic          w_good;
  logic          w_seed;
  logic          w_acc;
  logic          w_rej;
  logic [W-1:0]  w_old;
  logic [SW:0]   w_sum_wide;
  logic [SW-1:0] w_sum_acc;
  logic [SW:0]   w_round;
  logic [W-1:0]  w_avg_acc;
  logic [NW-1:0] w_ne_next;

  // S1: classify against the average currently on the output (may lag by two updates)
  always_comb begin
    w_diff    = {1'b0, raw_distance} - {1'b0, r_avg};
    w_absdiff = w_diff[W] ? (~w_diff + {{W{1'b0}}, 1'b1}) : w_diff;
    w_far     = w_absdiff > (W+1)'(MAX_JUMP);
    w_invalid = (raw_distance == '0) || (raw_distance == '1);
  end

  always_comb begin
    w_good     = r_s1_valid && !r_s1_invalid;
    w_seed     = w_good && (!r_seeded || (r_s1_far && (r_rej == RW'(REJECT_LIMIT - 1))));
    w_rej      = w_good && !w_seed && r_s1_far;
    w_acc      = w_good && !w_seed && !r_s1_far;
    w_old      = r_win[r_ptr];
    w_sum_wide = {1'b0, r_sum} + {{(LG+1){1'b0}}, r_s1_sample} - {{(LG+1){1'b0}}, w_old};
    w_sum_acc  = w_sum_wide[SW-1:0];
    w_round    = {1'b0, w_sum_acc} + (SW+1)'(DEPTH / 2);
    w_avg_acc  = w_round[LG +: W];
    w_ne_next  = (r_ne == NW'(NO_ECHO_LIMIT)) ? r_ne : r_ne + NW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sample  <= '0;
      r_s1_invalid <= 1'b0;
      r_s1_far     <= 1'b0;
      r_sum        <= '0;
      r_ptr        <= '0;
      r_rej        <= '0;
      r_ne         <= '0;
      r_avg        <= '0;
      r_avg_valid  <= 1'b0;
      r_seeded     <= 1'b0;
      r_no_target  <= 1'b0;
    end else begin
      r_s1_valid   <= dist_valid;
      r_s1_sample  <= raw_distance;
      r_s1_invalid <= w_invalid;
      r_s1_far     <= w_far;
      r_avg_valid  <= w_seed || w_acc;
      if (r_s1_valid && r_s1_invalid) begin
        r_ne        <= w_ne_next;
        r_no_target <= (w_ne_next == NW'(NO_ECHO_LIMIT));
      end else if (r_s1_valid) begin
        r_ne        <= '0;
        r_no_target <= 1'b0;
      end
      if (w_seed) begin
        r_sum    <= {r_s1_sample, {LG{1'b0}}};
        r_ptr    <= '0;
        r_rej    <= '0;
        r_seeded <= 1'b1;
        r_avg    <= r_s1_sample;
      end else if (w_acc) begin
        r_sum <= w_sum_acc;
        r_ptr <= r_ptr + LG'(1);
        r_rej <= '0;
        r_avg <= w_avg_acc;
      end else if (w_rej) begin
        r_rej <= r_rej + RW'(1);
      end
    end
  end

  // Window storage has no reset; its contents only matter once seeded.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (w_seed) begin
        for (int i = 0; i < DEPTH; i++) r_win[i] <= r_s1_sample;
      end else if (w_acc) begin
        r_win[r_ptr] <= r_s1_sample;
      end
    end
  end

  assign avg_distance = r_avg;
  assign avg_valid    = r_avg_valid;
  assign seeded       = r_seeded;
  assign no_target    = r_no_target;

endmodule
